// File: rtl/reset_pkg.sv
// Shared definitions for the reset sequencer: FSM states, cause bits,
// register addresses and the software reset key.
package reset_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        HOLD     = 2'd1,
        WAIT_REL = 2'd2
    } rst_state_e;

    // Bit positions inside the cause register
    localparam int CAUSE_POR = 0;
    localparam int CAUSE_WDT = 1;
    localparam int CAUSE_BTN = 2;
    localparam int CAUSE_SW  = 3;

    // I/O register select values
    localparam logic REG_CAUSE = 1'b0;
    localparam logic REG_CTRL  = 1'b1;

    // Only this exact value written to REG_CTRL requests a reset
    localparam logic [7:0] SW_RESET_KEY = 8'hA5;

endpackage

// File: rtl/reset_debouncer.sv
// Button conditioning: 2-FF synchronizer on the raw active-low button,
// followed by a counter that only lets a level through once it has been
// stable for DEBOUNCE_CYCLES cycles. Output btn_db is active high (pressed).
module reset_debouncer #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_n,
    output logic btn_db
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             btn_db_q, btn_db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count while the synchronized level disagrees with the debounced one;
    // any agreement (a glitch ending) restarts the count from zero.
    always_comb begin
        cnt_d    = '0;
        btn_db_d = btn_db_q;
        if (sync2_q != btn_db_q) begin
            if (cnt_q == CNT_LAST) begin
                btn_db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchronizer stores the inverted button so reset value 0 means released
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            cnt_q    <= '0;
            btn_db_q <= 1'b0;
        end else begin
            sync1_q  <= ~btn_n;
            sync2_q  <= sync1_q;
            cnt_q    <= cnt_d;
            btn_db_q <= btn_db_d;
        end
    end

    assign btn_db = btn_db_q;

endmodule

// File: rtl/reset_controller.sv
// System reset sequencer: merges power-on, watchdog, button and software
// reset sources into one stretched active-low sys_reset_n, and exposes the
// reset cause and a saturating reset counter on a small I/O register pair.
module reset_controller
    import reset_pkg::*;
#(
    parameter int HOLD_CYCLES     = 16,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_n,
    input  logic       wdt_reset,
    input  logic       cs_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic       addr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       sys_reset_n
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    logic             btn_db;
    logic             wr_en, rd_en, sw_req, trig;
    logic [3:0]       cause_set, cause_clr;

    rst_state_e       state_q, state_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             sys_reset_n_q, sys_reset_n_d;
    logic [3:0]       cause_q, cause_d;
    logic [7:0]       rst_count_q, rst_count_d;

    reset_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_debouncer (
        .clk    (clk),
        .reset_n(reset_n),
        .btn_n  (btn_n),
        .btn_db (btn_db)
    );

    // Bus decode; writes only land while the system is running, so firmware
    // cannot clear causes or re-trigger while it is itself held in reset.
    assign wr_en  = !cs_n && rd_n && !wr_n && (state_q == RUN);
    assign rd_en  = !cs_n && !rd_n && wr_n;
    assign sw_req = wr_en && (addr == REG_CTRL) && (data_in == SW_RESET_KEY);
    assign trig   = wdt_reset | btn_db | sw_req;

    // Cause bits raised this cycle and write-1-to-clear mask
    always_comb begin
        cause_set            = '0;
        cause_set[CAUSE_WDT] = wdt_reset;
        cause_set[CAUSE_BTN] = btn_db;
        cause_set[CAUSE_SW]  = sw_req;
        cause_clr            = (wr_en && (addr == REG_CAUSE)) ? data_in[3:0] : 4'h0;
    end

    // Next-state logic; clear is applied first so a same-cycle set wins
    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        sys_reset_n_d = sys_reset_n_q;
        rst_count_d   = rst_count_q;
        cause_d       = cause_q & ~cause_clr;
        case (state_q)
            RUN: begin
                if (trig) begin
                    state_d       = HOLD;
                    hold_cnt_d    = '0;
                    sys_reset_n_d = 1'b0;
                    cause_d       = cause_d | cause_set;
                    if (rst_count_q != 8'hFF) begin
                        rst_count_d = rst_count_q + 8'd1;
                    end
                end
            end
            HOLD: begin
                // Late triggers are recorded but do not extend or recount
                cause_d = cause_d | cause_set;
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = WAIT_REL;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            WAIT_REL: begin
                if (!wdt_reset && !btn_db) begin
                    state_d       = RUN;
                    sys_reset_n_d = 1'b1;
                end
            end
            default: begin
                state_d       = HOLD;
                hold_cnt_d    = '0;
                sys_reset_n_d = 1'b0;
            end
        endcase
    end

    // State register; power-on behaves as a fresh hold with cause POR
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= HOLD;
            hold_cnt_q    <= '0;
            sys_reset_n_q <= 1'b0;
            cause_q       <= 4'h1;
            rst_count_q   <= 8'h00;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            sys_reset_n_q <= sys_reset_n_d;
            cause_q       <= cause_d;
            rst_count_q   <= rst_count_d;
        end
    end

    // Combinational read mux, zero when not addressed for read
    always_comb begin
        data_out = 8'h00;
        if (rd_en) begin
            data_out = (addr == REG_CAUSE) ? {4'h0, cause_q} : rst_count_q;
        end
    end

    assign sys_reset_n = sys_reset_n_q;

endmodule

// File: tb/tb_reset_controller.sv
// Bench for reset_controller with HOLD_CYCLES=16, DEBOUNCE_CYCLES=8.
// Inputs are driven on the falling edge and outputs sampled there too.
module tb_reset_controller;

    localparam int HOLD = 16;
    localparam int DEB  = 8;
    localparam int LOW  = HOLD + 1;

    logic       clk = 1'b0;
    logic       reset_n, btn_n, wdt_reset, cs_n, rd_n, wr_n, addr;
    logic [7:0] data_in, data_out;
    logic       sys_reset_n;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];
    int         exp_cnt;
    logic [7:0] exp_cause;

    typedef struct {
        logic       cs_n, rd_n, wr_n, addr;
        logic [7:0] exp;
        string      name;
    } vec_t;
    vec_t vecs[5];

    always #5 clk = ~clk;

    reset_controller #(
        .HOLD_CYCLES    (HOLD),
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .btn_n      (btn_n),
        .wdt_reset  (wdt_reset),
        .cs_n       (cs_n),
        .rd_n       (rd_n),
        .wr_n       (wr_n),
        .addr       (addr),
        .data_in    (data_in),
        .data_out   (data_out),
        .sys_reset_n(sys_reset_n)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; addr = 1'b0; data_in = 8'h00;
    endtask

    task automatic bump();
        exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
    endtask

    // Read through the scoreboard: expectation queued, DUT sample compared
    task automatic rd(input logic a, input logic [7:0] exp, input string name);
        cs_n = 1'b0; rd_n = 1'b0; wr_n = 1'b1; addr = a;
        exp_q.push_back(exp);
        #1;
        chk(name, data_out, exp_q.pop_front());
        idle();
    endtask

    task automatic wr(input logic a, input logic [7:0] d);
        cs_n = 1'b0; rd_n = 1'b1; wr_n = 1'b0; addr = a; data_in = d;
        tick();
        idle();
    endtask

    // Edges until sys_reset_n returns high, bounded
    task automatic count_low(output int n);
        n = 0;
        while (sys_reset_n !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
    endtask

    task automatic run_watch(input int n, output logic low_seen);
        low_seen = 1'b0;
        repeat (n) begin
            tick();
            if (sys_reset_n !== 1'b1) low_seen = 1'b1;
        end
    endtask

    initial begin
        int   n, bad;
        logic la, lb;
        reset_n = 1'b1; btn_n = 1'b1; wdt_reset = 1'b0;
        idle();
        #2 reset_n = 1'b0;
        #1;
        chk("por_sys_low", sys_reset_n, 1'b0);
        rd(1'b0, 8'h01, "por_cause_in_reset");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        count_low(n);
        chk("por_low_cycles", n, LOW);
        exp_cause = 8'h01; exp_cnt = 0;

        // Register read table
        vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h01, "rd_cause"};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, "rd_count"};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, "rd_no_cs"};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, "rd_no_rd"};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, "rd_rd_and_wr"};
        for (int i = 0; i < 5; i++) begin
            cs_n = vecs[i].cs_n; rd_n = vecs[i].rd_n; wr_n = vecs[i].wr_n; addr = vecs[i].addr;
            exp_q.push_back(vecs[i].exp);
            #1;
            chk(vecs[i].name, data_out, exp_q.pop_front());
            idle();
        end

        // Watchdog single-cycle pulse
        wr(1'b0, 8'h0F); exp_cause = 8'h00;
        rd(1'b0, exp_cause, "w1c_all");
        wdt_reset = 1'b1; tick(); wdt_reset = 1'b0;
        chk("wdt_low_next_edge", sys_reset_n, 1'b0);
        count_low(n);
        chk("wdt_low_cycles", n, LOW);
        bump(); exp_cause = 8'h02;
        rd(1'b0, exp_cause, "wdt_cause");
        rd(1'b1, 8'(exp_cnt), "wdt_count");

        // Watchdog held for 40 cycles
        wr(1'b0, 8'h0F);
        wdt_reset = 1'b1;
        repeat (40) tick();
        chk("wdt_held_low", sys_reset_n, 1'b0);
        wdt_reset = 1'b0;
        tick();
        chk("wdt_release_edge", sys_reset_n, 1'b1);
        bump(); exp_cause = 8'h02;
        rd(1'b1, 8'(exp_cnt), "wdt_held_count");

        // Software reset: wrong key, right key, key during hold
        wr(1'b0, 8'h0F);
        wr(1'b1, 8'h5A);
        run_watch(3, la);
        chk("sw_bad_key_no_reset", la, 1'b0);
        rd(1'b1, 8'(exp_cnt), "sw_bad_key_count");
        wr(1'b1, 8'hA5);
        chk("sw_key_reset", sys_reset_n, 1'b0);
        repeat (3) tick();
        wr(1'b1, 8'hA5);
        count_low(n);
        chk("sw_hold_not_restarted", n, LOW - 4);
        bump(); exp_cause = 8'h08;
        rd(1'b0, exp_cause, "sw_cause");
        rd(1'b1, 8'(exp_cnt), "sw_count_once");

        // Software key and watchdog in the same cycle
        wr(1'b0, 8'h0F);
        cs_n = 1'b0; rd_n = 1'b1; wr_n = 1'b0; addr = 1'b1; data_in = 8'hA5; wdt_reset = 1'b1;
        tick();
        idle(); wdt_reset = 1'b0;
        count_low(n);
        chk("sw_wdt_low_cycles", n, LOW);
        bump(); exp_cause = 8'h0A;
        rd(1'b0, exp_cause, "sw_wdt_cause");
        rd(1'b1, 8'(exp_cnt), "sw_wdt_count");

        // Button glitches shorter than the debounce window
        wr(1'b0, 8'h0F); exp_cause = 8'h00;
        for (int g = 1; g <= 6; g++) begin
            btn_n = 1'b0;
            run_watch(g, la);
            btn_n = 1'b1;
            run_watch(12, lb);
            chk($sformatf("btn_glitch_%0d", g), la | lb, 1'b0);
        end
        rd(1'b1, 8'(exp_cnt), "btn_glitch_count");

        // Stable press: 2 sync + 8 debounce edges, FSM reacts on the next
        btn_n = 1'b0;
        repeat (2 + DEB) tick();
        chk("btn_press_not_yet", sys_reset_n, 1'b1);
        tick();
        chk("btn_press_reset", sys_reset_n, 1'b0);
        repeat (30) tick();
        chk("btn_held_low", sys_reset_n, 1'b0);
        btn_n = 1'b1;
        repeat (2 + DEB) tick();
        chk("btn_release_not_yet", sys_reset_n, 1'b0);
        tick();
        chk("btn_release", sys_reset_n, 1'b1);
        bump(); exp_cause = 8'h04;
        rd(1'b0, exp_cause, "btn_cause");
        rd(1'b1, 8'(exp_cnt), "btn_count");

        // Clear of bit1 in the same cycle as a new watchdog trip
        wr(1'b0, 8'h0F);
        cs_n = 1'b0; rd_n = 1'b1; wr_n = 1'b0; addr = 1'b0; data_in = 8'h02; wdt_reset = 1'b1;
        tick();
        idle(); wdt_reset = 1'b0;
        rd(1'b0, 8'h02, "w1c_vs_trip");
        count_low(n);
        chk("w1c_vs_trip_low", n, LOW);
        bump();

        // Counter saturation
        bad = 0;
        for (int i = 0; i < 260; i++) begin
            wdt_reset = 1'b1; tick(); wdt_reset = 1'b0;
            count_low(n);
            if (n != LOW) bad++;
            bump();
        end
        chk("sat_low_cycles_bad", bad, 0);
        rd(1'b1, 8'(exp_cnt), "sat_count");

        // Power-on reset in the middle of a hold
        wdt_reset = 1'b1; tick(); wdt_reset = 1'b0;
        repeat (5) tick();
        reset_n = 1'b0;
        #1;
        chk("por_mid_hold_low", sys_reset_n, 1'b0);
        rd(1'b0, 8'h01, "por_mid_hold_cause");
        rd(1'b1, 8'h00, "por_mid_hold_count");
        tick();
        reset_n = 1'b1;
        count_low(n);
        chk("por_mid_hold_low_cycles", n, LOW);
        rd(1'b0, 8'h01, "por_after_cause");
        rd(1'b1, 8'h00, "por_after_count");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reset_controller.md
Name: reset_controller

Overview:
- Central reset sequencer for the TV80 SoC.
- Merges four reset sources into one stretched, glitch-free active-low system reset (`sys_reset_n`) that drives the CPU and all peripherals: power-on, watchdog trip, debounced external button, and a software request.
- The watchdog's `reset_n` is `sys_reset_n`, so a trip clears itself during the hold.
- Sits on the Z80 I/O bus so firmware can read the reset cause, clear it, count resets, and request a software reset.

Parameters:
- HOLD_CYCLES, 16, minimum cycles `sys_reset_n` is held low per reset event (≥2).
- DEBOUNCE_CYCLES, 50000, cycles `btn` must be stable before its debounced level changes (≥2).
- CNT_W, 16, width of the debounce and hold counters (must hold max(HOLD_CYCLES, DEBOUNCE_CYCLES)).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low power-on reset; the only reset of this block.
- btn_n  in  1  external reset button, active low, asynchronous to clk.
- wdt_reset  in  1  watchdog trip, active high, level (may last 1 cycle or be held).
- cs_n  in  1  I/O chip select, active low.
- rd_n  in  1  I/O read strobe, active low.
- wr_n  in  1  I/O write strobe, active low.
- addr  in  1  register select.
- data_in  in  8  write data.
- data_out  out  8  read data; 8'h00 when not selected for read.
- sys_reset_n  out  1  registered system reset, active low.

Behaviour:
- Async reset (`reset_n`=0):
  - state=HOLD, hold_cnt=0, `sys_reset_n`=0.
  - cause=8'h01 (POR), rst_count=0.
  - Synchronizer, debouncer and btn_db cleared (released).
- Button path:
  - `btn_n` passes a 2-FF synchronizer, giving btn_s (1 = pressed).
  - Debouncer counts while btn_s≠btn_db and resets the count when they are equal.
  - At count DEBOUNCE_CYCLES-1, btn_db<=btn_s and the count returns to 0.
- Trigger: trig = wdt_reset | btn_db | sw_req, where sw_req is a 1-cycle pulse on a write to addr1 with data 8'hA5 (any other value is ignored).
- State machine (one state register, all transitions on posedge clk):
  - RUN:
    - On trig: go to HOLD, hold_cnt<=0, `sys_reset_n`<=0 on the same edge.
    - Set the cause bits for every source active this cycle (several may be set at once).
    - rst_count<=rst_count+1, saturating at 8'hFF.
  - HOLD:
    - hold_cnt increments each cycle.
    - When hold_cnt==HOLD_CYCLES-1, go to WAIT_REL.
    - Triggers here OR into cause but neither restart the hold nor count.
  - WAIT_REL:
    - Stay while wdt_reset=1 or btn_db=1.
    - Otherwise go to RUN and set `sys_reset_n`<=1 on that edge.
  - Minimum low time is therefore HOLD_CYCLES+1 cycles after the trigger edge, or after `reset_n` deassertion.
- Cause register bits: [0] POR, [1] WDT, [2] BTN, [3] SW; [7:4] read 0.
- Register map:
  - addr0 read: cause. addr0 write: write-1-to-clear, cause[3:0] &= ~data_in[3:0].
  - addr1 read: rst_count. addr1 write: software reset key.
  - A write is a cycle with !cs_n & !rd_n... precisely: !cs_n & rd_n & !wr_n. Writes are accepted only in RUN; they are ignored during HOLD and WAIT_REL.
  - A set and a clear of the same cause bit in the same cycle: set wins.
  - Reads are combinational: data_out = (!cs_n & !rd_n & wr_n) ? mux(addr) : 8'h00.
- `reset_n` asserted mid-HOLD or mid-WAIT_REL: immediate restart exactly as power-on (cause=8'h01, count=0).
- An 8'hA5 write to addr1 and a wdt_reset in the same RUN cycle: single reset, cause bits [1] and [3] both set.

Decomposition:
- Shared package `reset_pkg`:
  - State encodings RUN/HOLD/WAIT_REL.
  - Cause bit indices CAUSE_POR/WDT/BTN/SW.
  - Register addresses REG_CAUSE=0, REG_CTRL=1.
  - SW_RESET_KEY=8'hA5.
- One sub-module: `reset_debouncer` (2-FF synchronizer plus debounce counter, parameter DEBOUNCE_CYCLES, output btn_db).

Test Plan (HOLD_CYCLES=16, DEBOUNCE_CYCLES=8):
- POR:
  - Stimulus: release `reset_n`.
  - Response: `sys_reset_n` low exactly 17 cycles, then 1; read addr0=8'h01, addr1=8'h00; data_out=8'h00 when not selected.
- WDT pulse:
  - Stimulus: write addr0 8'h0F (cause→8'h00), then a 1-cycle wdt_reset.
  - Response: `sys_reset_n` low on the next edge for 17 cycles; cause=8'h02, count=8'h01.
  - Stimulus: hold wdt_reset 40 cycles. Response: `sys_reset_n` stays low until the edge after wdt_reset falls.
- Software reset:
  - Stimulus: write addr1 8'h5A. Response: no reset.
  - Stimulus: write addr1 8'hA5. Response: reset; cause gains bit3 (8'h08 after a prior clear).
  - Stimulus: the same 8'hA5 write issued during HOLD. Response: ignored, no count.
- Button:
  - Stimulus: `btn_n` glitches of 1–6 cycles. Response: no reset.
  - Stimulus: stable press. Response: reset after 2+8 cycles, cause bit2 set; `sys_reset_n` held low until 2+8 cycles after release.
- Boundaries:
  - Stimulus: 260 WDT trips. Response: count saturates at 8'hFF.
  - Stimulus: W1C of bit1 in the same cycle as a new trip. Response: bit1 remains 1.
  - Stimulus: `reset_n` pulse mid-HOLD. Response: cause=8'h01, count=0, fresh 17-cycle hold.
